lfsr_stream_checker: RTL and testbench

Receive-side companion to the 32-bit LFSR random-word generator. Consumes the generator's word stream (one word per valid beat), locks onto the sequence, then predicts each next word and flags any deviation. Used as the on-chip health monitor and sequence checker at the consumer end of the random-number path.

---
 rtl/lfsr_stream_checker.sv | 150 +++++++++++++++
 tb/tb_lfsr_stream_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for the 32-bit LFSR word stream: locks onto the sequence,
// predicts each next word and flags deviations, with saturating health counters.
module lfsr_stream_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int MISS_LIMIT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_word,
  input  logic             clear_counts,
  output logic             locked,
  output logic [1:0]       state,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count,
  output logic             zero_seen
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [31:0]         ref_reg, ref_next;
  logic [RUN_W-1:0]    run_reg, run_next;
  logic [MISS_W-1:0]   miss_reg, miss_next;
  logic                mismatch_reg, mismatch_next;
  logic [CNT_W-1:0]    err_reg, err_next;
  logic [CNT_W-1:0]    word_reg, word_next;
  logic                zero_reg, zero_next;
  logic [31:0]         pred;
  logic                word_is_zero;
  logic                err_inc, word_inc, zero_set;

  assign pred         = {ref_reg[30:0], ref_reg[31] ^ ref_reg[28] ^ ref_reg[25] ^ ref_reg[24]};
  assign word_is_zero = (in_word == 32'd0);

  always_comb begin
    state_next    = state_reg;
    ref_next      = ref_reg;
    run_next      = run_reg;
    miss_next     = miss_reg;
    mismatch_next = 1'b0;
    err_inc       = 1'b0;
    word_inc      = 1'b0;
    zero_set      = 1'b0;
    if (in_valid) begin
      case (state_reg)
        HUNT: begin
          if (word_is_zero) begin
            zero_set = 1'b1;
          end else begin
            ref_next   = in_word;
            run_next   = '0;
            state_next = VERIFY;
          end
        end
        VERIFY: begin
          if (word_is_zero) begin
            zero_set   = 1'b1;
            state_next = HUNT;
          end else if (in_word == pred) begin
            ref_next = in_word;
            run_next = run_reg + RUN_W'(1);
            if (run_reg == RUN_W'(LOCK_COUNT - 1)) begin
              state_next = LOCKED;
              miss_next  = '0;
            end
          end else begin
            // Any non-zero surprise becomes the new candidate seed.
            ref_next = in_word;
            run_next = '0;
          end
        end
        LOCKED: begin
          word_inc = 1'b1;
          zero_set = word_is_zero;
          if (in_word == pred) begin
            ref_next  = in_word;
            miss_next = '0;
          end else begin
            // Flywheel on the prediction so one corrupted word does not misalign us.
            mismatch_next = 1'b1;
            err_inc       = 1'b1;
            ref_next      = pred;
            miss_next     = miss_reg + MISS_W'(1);
            if (miss_reg == MISS_W'(MISS_LIMIT - 1)) begin
              state_next = HUNT;
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  always_comb begin
    err_next  = err_reg;
    word_next = word_reg;
    zero_next = zero_reg | zero_set;
    if (err_inc && (err_reg != {CNT_W{1'b1}})) begin
      err_next = err_reg + CNT_W'(1);
    end
    if (word_inc && (word_reg != {CNT_W{1'b1}})) begin
      word_next = word_reg + CNT_W'(1);
    end
    if (clear_counts) begin
      err_next  = '0;
      word_next = '0;
      zero_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= HUNT;
      ref_reg      <= '0;
      run_reg      <= '0;
      miss_reg     <= '0;
      mismatch_reg <= 1'b0;
      err_reg      <= '0;
      word_reg     <= '0;
      zero_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ref_reg      <= ref_next;
      run_reg      <= run_next;
      miss_reg     <= miss_next;
      mismatch_reg <= mismatch_next;
      err_reg      <= err_next;
      word_reg     <= word_next;
      zero_reg     <= zero_next;
    end
  end

  assign state      = state_reg;
  assign locked     = (state_reg == LOCKED);
  assign mismatch   = mismatch_reg;
  assign err_count  = err_reg;
  assign word_count = word_reg;
  assign zero_seen  = zero_reg;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench for lfsr_stream_checker: lock-on, taps, flywheel, lock loss,
// zero words, counter saturation/clear, idle gaps and asynchronous reset.
module tb_lfsr_stream_checker;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [31:0]      in_word;
  logic             clear_counts;
  logic             locked;
  logic [1:0]       state;
  logic             mismatch;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] word_count;
  logic             zero_seen;

  int n_tests = 0;
  int n_fail  = 0;

  lfsr_stream_checker #(
    .LOCK_COUNT(4),
    .MISS_LIMIT(3),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_word     (in_word),
    .clear_counts(clear_counts),
    .locked      (locked),
    .state       (state),
    .mismatch    (mismatch),
    .err_count   (err_count),
    .word_count  (word_count),
    .zero_seen   (zero_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Generator step, used to extend known-good streams beyond the hand tables.
  function automatic logic [31:0] gen_next(input logic [31:0] r);
    return {r[30:0], r[31] ^ r[28] ^ r[25] ^ r[24]};
  endfunction

  // Called at a falling edge; returns at the next falling edge with the beat absorbed.
  task automatic drive(input logic v, input logic [31:0] w, input logic c);
    in_valid     = v;
    in_word      = w;
    clear_counts = c;
    @(negedge clk);
    in_valid     = 1'b0;
    clear_counts = 1'b0;
    $display("[TB] v=%0b w=0x%08h clr=%0b -> state=%0d locked=%0b mm=%0b err=%0d words=%0d zero=%0b",
             v, w, c, state, locked, mismatch, err_count, word_count, zero_seen);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] lock_seq [5] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0004,
                                32'h0000_0008, 32'h0000_0010};
  logic [31:0] tap_seq  [5] = '{32'h8910_0000, 32'h1220_0000, 32'h2440_0000,
                                32'h4880_0000, 32'h9100_0000};
  logic [31:0] bad_seq  [3] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D};
  logic [1:0]  lock_st  [5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};

  initial begin
    logic [31:0] gen;
    int          exp_err;

    rst = 1'b1; in_valid = 1'b0; in_word = '0; clear_counts = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_mismatch", 32'(mismatch), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_words", 32'(word_count), 32'd0);
    check("rst_zero", 32'(zero_seen), 32'd0);
    rst = 1'b0;

    // Lock-on: seed plus four matches.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, lock_seq[i], 1'b0);
      check("lock_state", 32'(state), 32'(lock_st[i]));
      check("lock_locked", 32'(locked), (i == 4) ? 32'd1 : 32'd0);
    end
    check("lock_err", 32'(err_count), 32'd0);
    check("lock_words", 32'(word_count), 32'd0);

    // Tap check: correct successor of 0x91000000.
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, tap_seq[i], 1'b0);
    check("tap_locked", 32'(locked), 32'd1);
    drive(1'b1, 32'h2200_0001, 1'b0);
    check("tap_mm", 32'(mismatch), 32'd0);
    check("tap_err", 32'(err_count), 32'd0);
    check("tap_words", 32'(word_count), 32'd1);

    // Tap check with corrupted word, then flywheel recovery.
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, tap_seq[i], 1'b0);
    drive(1'b1, 32'h2200_0000, 1'b0);
    check("corrupt_mm", 32'(mismatch), 32'd1);
    check("corrupt_err", 32'(err_count), 32'd1);
    drive(1'b1, 32'h4400_0003, 1'b0);
    check("fly_mm", 32'(mismatch), 32'd0);
    check("fly_err", 32'(err_count), 32'd1);
    check("fly_locked", 32'(locked), 32'd1);

    // Lock loss: three consecutive misses.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, bad_seq[i], 1'b0);
      check("loss_mm", 32'(mismatch), 32'd1);
      check("loss_err", 32'(err_count), 32'(2 + i));
      check("loss_locked", 32'(locked), (i == 2) ? 32'd0 : 32'd1);
    end
    check("loss_state", 32'(state), 32'd0);
    check("loss_words", 32'(word_count), 32'd5);
    drive(1'b0, 32'h0, 1'b0);
    check("loss_idle_mm", 32'(mismatch), 32'd0);

    // Relock from HUNT with random idle gaps: same timing counted in beats.
    for (int i = 0; i < 5; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) drive(1'b0, 32'hFFFF_FFFF, 1'b0);
      check("gap_idle_state", 32'(state), (i == 0) ? 32'd0 : 32'd1);
      drive(1'b1, lock_seq[i], 1'b0);
      check("gap_state", 32'(state), 32'(lock_st[i]));
    end
    check("gap_locked", 32'(locked), 32'd1);
    check("gap_err", 32'(err_count), 32'd4);

    // Zero words in HUNT and VERIFY, then clears.
    do_reset();
    drive(1'b1, 32'h0, 1'b0);
    check("zero_hunt_seen", 32'(zero_seen), 32'd1);
    check("zero_hunt_state", 32'(state), 32'd0);
    drive(1'b1, 32'h0000_0005, 1'b0);
    check("zero_seed_state", 32'(state), 32'd1);
    drive(1'b1, 32'h0, 1'b0);
    check("zero_verify_state", 32'(state), 32'd0);
    drive(1'b0, 32'h0, 1'b1);
    check("zero_clear", 32'(zero_seen), 32'd0);
    drive(1'b1, 32'h0, 1'b1);
    check("zero_clear_wins", 32'(zero_seen), 32'd0);

    // Saturation: alternate wrong/right so the miss limit is never reached.
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, lock_seq[i], 1'b0);
    gen = lock_seq[4];
    for (int i = 0; i < 20; i++) begin
      gen = gen_next(gen);
      drive(1'b1, ~gen, 1'b0);
      exp_err = (i + 1 > 15) ? 15 : i + 1;
      check("sat_mm", 32'(mismatch), 32'd1);
      check("sat_err", 32'(err_count), 32'(exp_err));
      gen = gen_next(gen);
      drive(1'b1, gen, 1'b0);
      check("sat_match_mm", 32'(mismatch), 32'd0);
    end
    check("sat_locked", 32'(locked), 32'd1);
    check("sat_words", 32'(word_count), 32'd15);
    gen = gen_next(gen);
    drive(1'b1, ~gen, 1'b1);
    check("clr_mm", 32'(mismatch), 32'd1);
    check("clr_err", 32'(err_count), 32'd0);
    check("clr_words", 32'(word_count), 32'd0);
    gen = gen_next(gen);
    drive(1'b1, 32'h0, 1'b0);
    check("lock_zero_mm", 32'(mismatch), 32'd1);
    check("lock_zero_err", 32'(err_count), 32'd1);
    check("lock_zero_seen", 32'(zero_seen), 32'd1);
    check("lock_zero_locked", 32'(locked), 32'd1);
    gen = gen_next(gen);
    drive(1'b1, gen, 1'b0);
    check("lock_zero_fly", 32'(mismatch), 32'd0);

    // Asynchronous reset in VERIFY with one match already counted.
    for (int i = 0; i < 3; i++) drive(1'b1, bad_seq[i], 1'b0);
    check("pre_rst_state", 32'(state), 32'd0);
    drive(1'b1, 32'h0000_0001, 1'b0);
    drive(1'b1, 32'h0000_0002, 1'b0);
    check("pre_rst_verify", 32'(state), 32'd1);
    check("pre_rst_err", 32'(err_count), 32'd4);
    #2 rst = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_err", 32'(err_count), 32'd0);
    check("arst_words", 32'(word_count), 32'd0);
    check("arst_zero", 32'(zero_seen), 32'd0);
    @(negedge clk);
    check("rst_hold_state", 32'(state), 32'd0);
    check("rst_hold_locked", 32'(locked), 32'd0);
    check("rst_hold_mm", 32'(mismatch), 32'd0);
    rst = 1'b0;
    drive(1'b1, 32'h0000_0004, 1'b0);
    check("post_rst_seed", 32'(state), 32'd1);
    drive(1'b1, 32'h0000_0008, 1'b0);
    drive(1'b1, 32'h0000_0010, 1'b0);
    drive(1'b1, 32'h0000_0020, 1'b0);
    check("post_rst_no_partial", 32'(locked), 32'd0);
    drive(1'b1, 32'h0000_0040, 1'b0);
    check("post_rst_lock", 32'(locked), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
